cp0_ctrl: RTL

- Coprocessor-0 controller at the M stage; the consumer of the exception code and branch-delay flag carried through the pipeline registers.
- Merges pipelined exceptions with external hardware interrupts and decides whether to trap.
- Drives `req`, which makes every pipeline register flush to the handler PC.
- Holds the SR, Cause, EPC and PRId registers and serves mtc0, mfc0 and eret.

---
 rtl/cp0_ctrl_pkg.sv | 32 +++
 rtl/cp0_int_arb.sv | 24 ++
 rtl/cp0_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the EPC computation used when a trap is taken.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT    = 0;
  localparam int unsigned SR_EXL_BIT   = 1;
  localparam int unsigned IM_LSB       = 10;
  localparam int unsigned CAUSE_BD_BIT = 31;
  localparam int unsigned EXC_LSB      = 2;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // Word-aligned EPC (bits [31:2]); a delay-slot trap returns to the branch.
  function automatic logic [29:0] epc_of(input logic [31:0] pc, input logic in_delay);
    return in_delay ? (pc[31:2] - 30'd1) : pc[31:2];
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Combinational trap arbitration: masked interrupts vs. pipelined exceptions.
module cp0_int_arb
  import cp0_defs::*;
#(
  parameter int unsigned HWINT_W = 6
) (
  input  logic [HWINT_W-1:0] hw_int,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  input  logic [4:0]         exc_in,
  output logic               int_req,
  output logic               exc_req,
  output logic [4:0]         exc_code
);

  always_comb begin
    int_req  = (|(hw_int & im)) & ie & ~exl;
    exc_req  = (exc_in != '0) & ~exl;
    // An interrupt wins over a simultaneous exception.
    exc_code = int_req ? EXC_INT : exc_in;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// M-stage coprocessor-0: SR/Cause/EPC/PRId, trap request, mtc0/mfc0/eret.
module cp0_ctrl
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID    = 32'h2021_0001,
  parameter int unsigned HWINT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        M_pc,
  input  logic [4:0]         ExcIn,
  input  logic               bd,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [31:0]        din,
  input  logic               eret,
  output logic               req,
  output logic [31:0]        dout,
  output logic [31:0]        epc_out
);

  logic [HWINT_W-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [HWINT_W-1:0] cause_ip;
  logic [4:0]         cause_exc;
  logic [29:0]        epc;

  logic               int_req;
  logic               exc_req;
  logic [4:0]         exc_code;
  logic [31:0]        sr_val;
  logic [31:0]        cause_val;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^M_pc[1:0];

  cp0_int_arb #(
    .HWINT_W (HWINT_W)
  ) u_arb (
    .hw_int   (HWInt),
    .im       (sr_im),
    .ie       (sr_ie),
    .exl      (sr_exl),
    .exc_in   (ExcIn),
    .int_req  (int_req),
    .exc_req  (exc_req),
    .exc_code (exc_code)
  );

  // Gated by reset so a pending exception cannot hold req high during reset.
  assign req = (int_req | exc_req) & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd;
        cause_exc <= exc_code;
        epc       <= epc_of(M_pc, bd);
      end else if (eret) begin
        sr_exl <= 1'b0;
      end else if (we) begin
        if (addr == REG_SR) begin
          sr_im  <= din[IM_LSB +: HWINT_W];
          sr_exl <= din[SR_EXL_BIT];
          sr_ie  <= din[SR_IE_BIT];
        end else if (addr == REG_EPC) begin
          epc <= din[31:2];
        end
      end
    end
  end

  always_comb begin
    sr_val                     = '0;
    sr_val[IM_LSB +: HWINT_W]  = sr_im;
    sr_val[SR_EXL_BIT]         = sr_exl;
    sr_val[SR_IE_BIT]          = sr_ie;

    cause_val                    = '0;
    cause_val[CAUSE_BD_BIT]      = cause_bd;
    cause_val[IM_LSB +: HWINT_W] = cause_ip;
    cause_val[EXC_LSB +: 5]      = cause_exc;

    case (addr)
      REG_SR:    dout = sr_val;
      REG_CAUSE: dout = cause_val;
      REG_EPC:   dout = {epc, 2'b00};
      REG_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end

  // Bypass lets an mtc0 EPC in the same cycle as eret take effect immediately.
  assign epc_out = (we && (addr == REG_EPC)) ? {din[31:2], 2'b00} : {epc, 2'b00};

endmodule
